// File: rtl/memlog_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : memlog_ctrl_pkg
// Brief  : Shared FSM encoding and helper function for the sample-log slice.
// Rev    : 1.0  initial release
// ============================================================================
package memlog_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage : memlog_ctrl_pkg
`default_nettype wire

// File: rtl/memlog_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : memlog_ctrl_if
// Brief  : Control, sample-tap and host read bus of the log controller.
// Rev    : 1.0  initial release
// ============================================================================
interface memlog_ctrl_if #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 10
);
    logic              log_run;
    logic              log_stop;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              log_busy;
    logic              log_done;
    logic [ADDR_W:0]   log_count;

    modport master (
        output log_run, log_stop, s_valid, s_data, rd_req, rd_addr,
        input  rd_data, rd_valid, log_busy, log_done, log_count
    );

    modport slave (
        input  log_run, log_stop, s_valid, s_data, rd_req, rd_addr,
        output rd_data, rd_valid, log_busy, log_done, log_count
    );
endinterface : memlog_ctrl_if
`default_nettype wire

// File: rtl/memlog_ctrl_memlog.sv
`default_nettype none
// ============================================================================
// Module : Memlog
// Brief  : Single-port log BRAM, read-first, optional output register.
// Rev    : 1.0  initial release
// ============================================================================
module Memlog
    import memlog_ctrl_pkg::*;
#(
    parameter int RAM_WIDTH       = 18,
    parameter int RAM_DEPTH       = 1024,
    parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  wire logic                          clka,
    input  wire logic [clog2(RAM_DEPTH)-1:0]   addra,
    input  wire logic [RAM_WIDTH-1:0]          dina,
    input  wire logic                          wea,
    input  wire logic                          ena,
    input  wire logic                          rsta,
    input  wire logic                          regcea,
    output logic      [RAM_WIDTH-1:0]          douta
);

    logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] r_ram_data;

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                r_mem[addra] <= dina;
            end
            r_ram_data <= r_mem[addra];
        end
    end

    generate
        if (RAM_PERFORMANCE == "HIGH_PERFORMANCE") begin : g_high_perf
            logic [RAM_WIDTH-1:0] r_douta;
            always_ff @(posedge clka) begin
                if (rsta) begin
                    r_douta <= '0;
                end else if (regcea) begin
                    r_douta <= r_ram_data;
                end
            end
            assign douta = r_douta;
        end else begin : g_low_latency
            assign douta = r_ram_data;
        end
    endgenerate

endmodule : Memlog
`default_nettype wire

// File: rtl/memlog_ctrl.sv
`default_nettype none
// ============================================================================
// Module : memlog_ctrl
// Brief  : Decimating sample capture into the log BRAM, host readback after.
// Rev    : 1.0  initial release
// ============================================================================
module memlog_ctrl
    import memlog_ctrl_pkg::*;
#(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 1024,
    parameter int DECIM  = 1
) (
    input wire logic      clka,
    input wire logic      rsta_n,
    memlog_ctrl_if.slave  bus
);

    localparam int              c_ADDR_W    = clog2(DEPTH);
    localparam logic [15:0]     c_DCNT_LAST = 16'(DECIM - 1);
    localparam logic [c_ADDR_W:0] c_LAST_WR = (c_ADDR_W + 1)'(DEPTH - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [c_ADDR_W:0]     r_count;
    logic [15:0]           r_dcnt;
    logic [1:0]            r_rd_pipe;
    logic                  w_write;
    logic                  w_rd_accept;
    logic [c_ADDR_W-1:0]   w_addra;
    logic [DATA_W-1:0]     w_douta;

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_write      = 1'b0;
        w_rd_accept  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_rd_accept = bus.rd_req;
                if (bus.log_run) begin
                    w_next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_write = bus.s_valid && (r_dcnt == 16'd0);
                // run beats stop; the last-address write closes the capture
                if (bus.log_run) begin
                    w_next_state = ST_CAPTURE;
                end else if (bus.log_stop) begin
                    w_next_state = ST_DONE;
                end else if (w_write && (r_count == c_LAST_WR)) begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // r_count doubles as the write pointer; it stops at DEPTH so never wraps
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_count <= '0;
            r_dcnt  <= '0;
        end else if (bus.log_run) begin
            r_count <= '0;
            r_dcnt  <= '0;
        end else if ((r_state == ST_CAPTURE) && bus.s_valid) begin
            r_dcnt <= (r_dcnt == c_DCNT_LAST) ? 16'd0 : r_dcnt + 16'd1;
            if (w_write) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_rd_pipe <= 2'b00;
        end else begin
            r_rd_pipe <= {r_rd_pipe[0], w_rd_accept};
        end
    end

    assign w_addra = (r_state == ST_CAPTURE) ? r_count[c_ADDR_W-1:0] : bus.rd_addr;

    Memlog #(
        .RAM_WIDTH       (DATA_W),
        .RAM_DEPTH       (DEPTH),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
    ) u_memlog (
        .clka   (clka),
        .addra  (w_addra),
        .dina   (bus.s_data),
        .wea    (w_write),
        .ena    (w_write | w_rd_accept),
        .rsta   (~rsta_n),
        .regcea (r_rd_pipe[0]),
        .douta  (w_douta)
    );

    assign bus.rd_valid  = r_rd_pipe[1];
    assign bus.rd_data   = r_rd_pipe[1] ? w_douta : '0;
    assign bus.log_busy  = (r_state == ST_CAPTURE);
    assign bus.log_done  = (r_state == ST_DONE);
    assign bus.log_count = r_count;

endmodule : memlog_ctrl
`default_nettype wire

// File: tb/tb_memlog_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_memlog_ctrl
// Brief  : Self-checking bench for memlog_ctrl (DEPTH=16, DECIM=1 and DECIM=3).
// Rev    : 1.0  initial release
// ============================================================================
module tb_memlog_ctrl;

    localparam int c_DATA_W = 18;
    localparam int c_DEPTH  = 16;
    localparam int c_ADDR_W = 4;

    logic clka;
    logic rsta_n;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    memlog_ctrl_if #(.DATA_W(c_DATA_W), .ADDR_W(c_ADDR_W)) bus_a ();
    memlog_ctrl_if #(.DATA_W(c_DATA_W), .ADDR_W(c_ADDR_W)) bus_b ();

    memlog_ctrl #(.DATA_W(c_DATA_W), .DEPTH(c_DEPTH), .DECIM(1)) u_dut_a (
        .clka   (clka),
        .rsta_n (rsta_n),
        .bus    (bus_a)
    );

    memlog_ctrl #(.DATA_W(c_DATA_W), .DEPTH(c_DEPTH), .DECIM(3)) u_dut_b (
        .clka   (clka),
        .rsta_n (rsta_n),
        .bus    (bus_b)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;
    always @(posedge clka) cyc = cyc + 1;

    typedef struct {
        logic [c_DATA_W-1:0] data;
        int                  cyc;
    } rd_exp_t;

    rd_exp_t q_a[$];
    rd_exp_t q_b[$];
    rd_exp_t e_a;
    rd_exp_t e_b;

    typedef struct {
        logic                run, stop, sv;
        logic [c_DATA_W-1:0] sd;
        logic                rq;
        logic [c_ADDR_W-1:0] ra;
        logic                acc;
        logic [c_DATA_W-1:0] rexp;
        logic                ebusy, edone;
        logic [c_ADDR_W:0]   ecnt;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input int run, input int stop, input int sv, input int sd,
                                input int rq, input int ra, input int acc, input int rexp,
                                input int busy, input int done, input int cnt);
        vec_t v;
        v.run   = 1'(run);
        v.stop  = 1'(stop);
        v.sv    = 1'(sv);
        v.sd    = c_DATA_W'(sd);
        v.rq    = 1'(rq);
        v.ra    = c_ADDR_W'(ra);
        v.acc   = 1'(acc);
        v.rexp  = c_DATA_W'(rexp);
        v.ebusy = 1'(busy);
        v.edone = 1'(done);
        v.ecnt  = (c_ADDR_W + 1)'(cnt);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic idle_a();
        bus_a.log_run  = 1'b0;
        bus_a.log_stop = 1'b0;
        bus_a.s_valid  = 1'b0;
        bus_a.s_data   = '0;
        bus_a.rd_req   = 1'b0;
        bus_a.rd_addr  = '0;
    endtask

    task automatic status_a(input string nm, input int busy, input int done, input int cnt);
        chk({nm, "_busy"},  32'(bus_a.log_busy),  32'(busy));
        chk({nm, "_done"},  32'(bus_a.log_done),  32'(done));
        chk({nm, "_count"}, 32'(bus_a.log_count), 32'(cnt));
    endtask

    task automatic rd_a(input int addr, input int d);
        bus_a.rd_req  = 1'b1;
        bus_a.rd_addr = c_ADDR_W'(addr);
        q_a.push_back('{data: c_DATA_W'(d), cyc: cyc + 2});
        step();
    endtask

    task automatic rd_b(input int addr, input int d);
        bus_b.rd_req  = 1'b1;
        bus_b.rd_addr = c_ADDR_W'(addr);
        q_b.push_back('{data: c_DATA_W'(d), cyc: cyc + 2});
        step();
    endtask

    // Read scoreboards: every rd_valid must match the head of the queue on its due cycle
    always @(negedge clka) begin
        if (bus_a.rd_valid === 1'b1) begin
            if (q_a.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL rd_a_spurious: rd_valid=1 data=%0d, expected rd_valid=0", bus_a.rd_data);
            end else begin
                e_a = q_a.pop_front();
                chk("rd_a_data", 32'(bus_a.rd_data), 32'(e_a.data));
                chk("rd_a_latency_cycle", cyc, e_a.cyc);
            end
        end else begin
            chk("rd_a_data_idle_zero", 32'(bus_a.rd_data), 32'd0);
            if (q_a.size() > 0 && q_a[0].cyc < cyc) begin
                e_a = q_a.pop_front();
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL rd_a_missing: rd_valid=0, expected data %0d at cycle %0d", e_a.data, e_a.cyc);
            end
        end
    end

    always @(negedge clka) begin
        if (bus_b.rd_valid === 1'b1) begin
            if (q_b.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL rd_b_spurious: rd_valid=1 data=%0d, expected rd_valid=0", bus_b.rd_data);
            end else begin
                e_b = q_b.pop_front();
                chk("rd_b_data", 32'(bus_b.rd_data), 32'(e_b.data));
                chk("rd_b_latency_cycle", cyc, e_b.cyc);
            end
        end else if (q_b.size() > 0 && q_b[0].cyc < cyc) begin
            e_b = q_b.pop_front();
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL rd_b_missing: rd_valid=0, expected data %0d at cycle %0d", e_b.data, e_b.cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rsta_n = 1'b0;
        idle_a();
        bus_b.log_run  = 1'b0;
        bus_b.log_stop = 1'b0;
        bus_b.s_valid  = 1'b0;
        bus_b.s_data   = '0;
        bus_b.rd_req   = 1'b0;
        bus_b.rd_addr  = '0;

        tbl[0]  = mk(1,0,0,0, 0,0,0,0, 1,0,0);
        tbl[1]  = mk(0,0,1,0, 1,3,0,0, 1,0,1);
        tbl[2]  = mk(0,0,0,0, 1,0,0,0, 1,0,1);
        tbl[3]  = mk(0,0,1,1, 0,0,0,0, 1,0,2);
        tbl[4]  = mk(0,0,1,2, 1,1,0,0, 1,0,3);
        tbl[5]  = mk(0,0,1,3, 0,0,0,0, 1,0,4);
        tbl[6]  = mk(0,1,1,4, 0,0,0,0, 0,1,5);
        tbl[7]  = mk(0,1,1,9, 0,0,0,0, 0,1,5);
        tbl[8]  = mk(0,0,0,0, 1,0,1,0, 0,1,5);
        tbl[9]  = mk(0,0,0,0, 1,1,1,1, 0,1,5);
        tbl[10] = mk(0,0,0,0, 1,2,1,2, 0,1,5);
        tbl[11] = mk(0,0,0,0, 1,3,1,3, 0,1,5);
        tbl[12] = mk(0,0,0,0, 1,4,1,4, 0,1,5);
        tbl[13] = mk(0,0,0,0, 0,0,0,0, 0,1,5);
        tbl[14] = mk(0,0,0,0, 0,0,0,0, 0,1,5);
        tbl[15] = mk(0,0,0,0, 1,5,1,5, 0,1,5);
        tbl[16] = mk(0,0,0,0, 0,0,0,0, 0,1,5);
        tbl[17] = mk(1,0,0,0, 0,0,0,0, 1,0,0);
        tbl[18] = mk(0,0,1,7, 0,0,0,0, 1,0,1);
        tbl[19] = mk(0,0,1,8, 0,0,0,0, 1,0,2);
        tbl[20] = mk(1,1,0,0, 0,0,0,0, 1,0,0);
        tbl[21] = mk(0,1,0,0, 0,0,0,0, 0,1,0);
        tbl[22] = mk(0,0,0,0, 1,0,1,7, 0,1,0);
        tbl[23] = mk(0,0,0,0, 0,0,0,0, 0,1,0);
        tbl[24] = mk(0,0,0,0, 0,0,0,0, 0,1,0);

        step();
        step();
        status_a("reset", 0, 0, 0);
        chk("reset_rd_valid", 32'(bus_a.rd_valid), 32'd0);
        chk("reset_rd_data",  32'(bus_a.rd_data),  32'd0);
        rsta_n = 1'b1;
        step();

        // Fill to the last address; samples past it are dropped
        bus_a.log_run = 1'b1;
        step();
        bus_a.log_run = 1'b0;
        status_a("run_start", 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            bus_a.s_valid = 1'b1;
            bus_a.s_data  = c_DATA_W'(i);
            step();
            if (i == 14) status_a("fill_15", 1, 0, 15);
            if (i == 15) status_a("fill_full", 0, 1, 16);
        end
        idle_a();
        status_a("fill_after_drop", 0, 1, 16);
        for (int a = 0; a < c_DEPTH; a++) rd_a(a, a);
        idle_a();
        repeat (4) step();

        // Restart from DONE overwrites from address 0; old words above count remain
        bus_a.log_run = 1'b1;
        step();
        bus_a.log_run = 1'b0;
        status_a("rerun", 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            bus_a.s_valid = 1'b1;
            bus_a.s_data  = c_DATA_W'(100 + i);
            step();
        end
        bus_a.s_valid  = 1'b0;
        bus_a.log_stop = 1'b1;
        step();
        bus_a.log_stop = 1'b0;
        status_a("rerun_stop", 0, 1, 3);
        rd_a(0, 100);
        rd_a(1, 101);
        rd_a(2, 102);
        rd_a(3, 3);
        idle_a();
        repeat (4) step();

        for (int r = 0; r < 25; r++) begin
            bus_a.log_run  = tbl[r].run;
            bus_a.log_stop = tbl[r].stop;
            bus_a.s_valid  = tbl[r].sv;
            bus_a.s_data   = tbl[r].sd;
            bus_a.rd_req   = tbl[r].rq;
            bus_a.rd_addr  = tbl[r].ra;
            if (tbl[r].acc) q_a.push_back('{data: tbl[r].rexp, cyc: cyc + 2});
            step();
            status_a($sformatf("tbl%0d", r), 32'(tbl[r].ebusy), 32'(tbl[r].edone), 32'(tbl[r].ecnt));
        end
        idle_a();
        repeat (3) step();

        // Reset mid-capture
        bus_a.log_run = 1'b1;
        step();
        bus_a.log_run = 1'b0;
        bus_a.s_valid = 1'b1;
        bus_a.s_data  = 18'd50;
        step();
        bus_a.s_data  = 18'd51;
        step();
        bus_a.s_valid = 1'b0;
        status_a("pre_reset_cap", 1, 0, 2);
        rsta_n = 1'b0;
        #1;
        status_a("reset_mid_capture", 0, 0, 0);
        step();
        step();
        rsta_n = 1'b1;
        step();

        // Reset while the read word is on the bus
        bus_a.rd_req  = 1'b1;
        bus_a.rd_addr = 4'd1;
        step();
        bus_a.rd_req  = 1'b0;
        step();
        chk("pre_reset_rd_valid", 32'(bus_a.rd_valid), 32'd1);
        chk("pre_reset_rd_data",  32'(bus_a.rd_data),  32'd51);
        rsta_n = 1'b0;
        #1;
        chk("reset_mid_read_valid", 32'(bus_a.rd_valid), 32'd0);
        chk("reset_mid_read_data",  32'(bus_a.rd_data),  32'd0);
        status_a("reset_mid_read", 0, 0, 0);
        step();
        rsta_n = 1'b1;
        step();
        rd_a(0, 50);
        rd_a(1, 51);
        idle_a();
        repeat (4) step();

        // Decimation by 3 with random gaps between samples
        bus_b.log_run = 1'b1;
        step();
        bus_b.log_run = 1'b0;
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 2)) step();
            bus_b.s_valid = 1'b1;
            bus_b.s_data  = c_DATA_W'(i);
            step();
            bus_b.s_valid = 1'b0;
        end
        bus_b.log_stop = 1'b1;
        step();
        bus_b.log_stop = 1'b0;
        chk("decim_busy",  32'(bus_b.log_busy),  32'd0);
        chk("decim_done",  32'(bus_b.log_done),  32'd1);
        chk("decim_count", 32'(bus_b.log_count), 32'd4);
        rd_b(0, 0);
        rd_b(1, 3);
        rd_b(2, 6);
        rd_b(3, 9);
        bus_b.rd_req = 1'b0;
        repeat (4) step();

        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_memlog_ctrl
`default_nettype wire
